deconvolution_seq: RTL and testbench

//  Sequential inverse of the packed convolution block. Given kernel h (signal1) and

---
 rtl/deconvolution_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_deconvolution_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/deconvolution_seq.sv
// Sequential deconvolution by forward substitution: recovers x from kernel h and y = h*x.
// Optional residual tail check is built when DECONV_TAIL_CHECK_EN is defined.
module deconvolution_seq #(
    parameter int N    = 16,
    parameter int LEN1 = 3,
    parameter int LEN2 = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN1*N-1:0]             signal1,
    input  logic [(LEN1+LEN2-1)*2*N-1:0]  conv_in,
    output logic                          busy,
    output logic                          done,
    output logic [LEN2*N-1:0]             signal2_out,
    output logic                          div_zero,
    output logic                          inexact,
    output logic                          overflow,
    output logic                          tail_err
);
    localparam int LY   = LEN1 + LEN2 - 1;
    localparam int ACCW = 2*N + $clog2(LEN1) + 1;
    localparam int KW   = $clog2(LEN1);
    localparam int XW   = (LEN2 > 1) ? $clog2(LEN2) : 1;
    localparam int YW   = $clog2(LY);
    localparam int DW   = $clog2(ACCW);
    localparam logic [ACCW-1:0] QNEG = {{(ACCW-N){1'b0}}, 1'b1, {(N-1){1'b0}}};
    localparam logic [ACCW-1:0] QPOS = QNEG - 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT, S_MAC, S_DIV, S_STORE,
`ifdef DECONV_TAIL_CHECK_EN
        S_TMAC, S_TCMP,
`endif
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic signed [N-1:0]    h_r   [LEN1];
    logic signed [2*N-1:0]  y_r   [LY];
    logic signed [N-1:0]    x_buf [LEN2];
    logic signed [ACCW-1:0] acc;
    logic [ACCW-1:0]        q;
    logic [N-1:0]           rem;
    logic [XW-1:0]          n;
    logic [KW-1:0]          k;
    logic [DW-1:0]          dcnt;
    logic                   st_dz, st_inx, st_ovf;
`ifdef DECONV_TAIL_CHECK_EN
    logic [KW-1:0]          j;
    logic                   st_terr;
`endif

    // datapath combinational helpers
    logic [KW-1:0]          mn;
    logic signed [N-1:0]    xm;
    logic signed [2*N-1:0]  prod;
    logic signed [ACCW-1:0] prod_x;
    logic signed [2*N-1:0]  yv;
    logic signed [ACCW-1:0] yv_x;
    logic [ACCW-1:0]        abs_acc, dsrc;
    logic [N-1:0]           dmag, rsrc;
    logic [N:0]             tr, tdiff;
    logic                   ge, neg, sat;
    logic signed [N-1:0]    xq;
    int                     ti;

    assign busy = (state != S_IDLE);

    always_comb begin
        mn = KW'(LEN1-1);
        if (int'(n) < LEN1-1) mn = KW'(n);
    end

    // shared multiplier: forward MAC reads x[n-k]; the tail reads x[LEN2-1+j-k] (zero if before x[0])
    always_comb begin
        ti = 0;
        xm = x_buf[XW'(int'(n) - int'(k))];
`ifdef DECONV_TAIL_CHECK_EN
        if (state == S_TMAC) begin
            ti = LEN2 - 1 + int'(j) - int'(k);
            xm = (ti >= 0) ? x_buf[XW'(ti)] : '0;
        end
`endif
        prod   = h_r[k] * xm;
        prod_x = {{(ACCW-2*N){prod[2*N-1]}}, prod};
    end

    always_comb begin
        yv = y_r[YW'(n)];
`ifdef DECONV_TAIL_CHECK_EN
        if (state == S_TCMP) yv = y_r[YW'(LEN2 - 1 + int'(j))];
`endif
        yv_x = {{(ACCW-2*N){yv[2*N-1]}}, yv};
    end

    // restoring division: first DIV cycle pulls the dividend straight from |acc|
    always_comb begin
        abs_acc = acc[ACCW-1] ? ACCW'(-acc) : ACCW'(acc);
        dmag    = h_r[0][N-1] ? N'(-h_r[0]) : h_r[0];
        dsrc    = (dcnt == '0) ? abs_acc : q;
        rsrc    = (dcnt == '0) ? '0 : rem;
        tr      = {rsrc, dsrc[ACCW-1]};
        tdiff   = tr - {1'b0, dmag};
        ge      = ~tdiff[N];
    end

    always_comb begin
        neg = acc[ACCW-1] ^ h_r[0][N-1];
        sat = neg ? (q > QNEG) : (q > QPOS);
        if (sat) xq = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else     xq = neg ? N'(-q) : N'(q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = (h_r[0] == '0) ? S_DONE : S_INIT;
            S_INIT:  state_nx = (mn == '0) ? S_DIV : S_MAC;
            S_MAC:   if (k == mn) state_nx = S_DIV;
            S_DIV:   if (dcnt == DW'(ACCW-1)) state_nx = S_STORE;
            S_STORE: begin
                if (n == XW'(LEN2-1)) begin
`ifdef DECONV_TAIL_CHECK_EN
                    state_nx = S_TMAC;
`else
                    state_nx = S_DONE;
`endif
                end else begin
                    state_nx = S_INIT;
                end
            end
`ifdef DECONV_TAIL_CHECK_EN
            S_TMAC:  if (k == KW'(LEN1-1)) state_nx = S_TCMP;
            S_TCMP:  state_nx = (j == KW'(LEN1-1)) ? S_DONE : S_TMAC;
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN1; i++) h_r[i] <= '0;
            for (int i = 0; i < LY; i++)   y_r[i] <= '0;
            for (int i = 0; i < LEN2; i++) x_buf[i] <= '0;
            acc         <= '0;
            q           <= '0;
            rem         <= '0;
            n           <= '0;
            k           <= '0;
            dcnt        <= '0;
            st_dz       <= 1'b0;
            st_inx      <= 1'b0;
            st_ovf      <= 1'b0;
            done        <= 1'b0;
            signal2_out <= '0;
            div_zero    <= 1'b0;
            inexact     <= 1'b0;
            overflow    <= 1'b0;
`ifdef DECONV_TAIL_CHECK_EN
            j           <= '0;
            st_terr     <= 1'b0;
            tail_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    for (int i = 0; i < LEN1; i++) h_r[i] <= signal1[i*N +: N];
                    for (int i = 0; i < LY; i++)   y_r[i] <= conv_in[i*2*N +: 2*N];
                    st_dz  <= 1'b0;
                    st_inx <= 1'b0;
                    st_ovf <= 1'b0;
`ifdef DECONV_TAIL_CHECK_EN
                    st_terr <= 1'b0;
`endif
                end
                S_LOAD: begin
                    n     <= '0;
                    st_dz <= (h_r[0] == '0);
                end
                S_INIT: begin
                    acc  <= yv_x;
                    k    <= KW'(1);
                    dcnt <= '0;
                end
                S_MAC: begin
                    acc <= acc - prod_x;
                    k   <= k + KW'(1);
                end
                S_DIV: begin
                    q    <= {dsrc[ACCW-2:0], ge};
                    rem  <= ge ? tdiff[N-1:0] : tr[N-1:0];
                    dcnt <= dcnt + DW'(1);
                end
                S_STORE: begin
                    x_buf[n] <= xq;
                    st_ovf   <= st_ovf | sat;
                    st_inx   <= st_inx | (rem != '0);
                    n        <= n + XW'(1);
`ifdef DECONV_TAIL_CHECK_EN
                    j   <= KW'(1);
                    k   <= KW'(1);
                    acc <= '0;
`endif
                end
`ifdef DECONV_TAIL_CHECK_EN
                S_TMAC: begin
                    acc <= acc + prod_x;
                    k   <= k + KW'(1);
                end
                S_TCMP: begin
                    if (acc != yv_x) st_terr <= 1'b1;
                    j   <= j + KW'(1);
                    k   <= j + KW'(1);
                    acc <= '0;
                end
`endif
                S_DONE: begin
                    for (int i = 0; i < LEN2; i++)
                        signal2_out[i*N +: N] <= st_dz ? '0 : x_buf[i];
                    div_zero <= st_dz;
                    inexact  <= st_dz ? 1'b0 : st_inx;
                    overflow <= st_dz ? 1'b0 : st_ovf;
`ifdef DECONV_TAIL_CHECK_EN
                    tail_err <= st_dz ? 1'b0 : st_terr;
`endif
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifndef DECONV_TAIL_CHECK_EN
    assign tail_err = 1'b0;
`endif

endmodule

// File: tb/tb_deconvolution_seq.sv
// Randomized self-checking bench for deconvolution_seq against an arithmetic reference model.
module tb_deconvolution_seq;
    localparam int N    = 16;
    localparam int LEN1 = 3;
    localparam int LEN2 = 4;
    localparam int LY   = LEN1 + LEN2 - 1;
    localparam int ACCW = 2*N + $clog2(LEN1) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [LEN1*N-1:0]     signal1 = '0;
    logic [LY*2*N-1:0]     conv_in = '0;
    logic                  busy, done, div_zero, inexact, overflow, tail_err;
    logic [LEN2*N-1:0]     signal2_out;

    deconvolution_seq #(.N(N), .LEN1(LEN1), .LEN2(LEN2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signal1(signal1), .conv_in(conv_in),
        .busy(busy), .done(done), .signal2_out(signal2_out), .div_zero(div_zero),
        .inexact(inexact), .overflow(overflow), .tail_err(tail_err)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint hm[LEN1], ym[LY], xe[LEN2], xprev[LEN2];
    bit     e_inx, e_ovf, e_dz, e_te, p_inx, p_ovf, p_dz, p_te;
    int     e_lat;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // forward substitution with integer division (truncates toward zero) and saturation
    task automatic model();
        longint acc, qv, lo, hi, s;
        int     m;
        lo = -(longint'(1) << (N-1));
        hi = (longint'(1) << (N-1)) - 1;
        e_dz = (hm[0] == 0);
        e_inx = 0; e_ovf = 0; e_te = 0; e_lat = 2;
        for (int i = 0; i < LEN2; i++) xe[i] = 0;
        if (!e_dz) begin
            for (int i = 0; i < LEN2; i++) begin
                m = (i < LEN1-1) ? i : LEN1-1;
                acc = ym[i];
                for (int kk = 1; kk <= m; kk++) acc -= hm[kk] * xe[i-kk];
                qv = acc / hm[0];
                if (acc % hm[0] != 0) e_inx = 1;
                if (qv > hi) begin qv = hi; e_ovf = 1; end
                if (qv < lo) begin qv = lo; e_ovf = 1; end
                xe[i] = qv;
                e_lat += 2 + m + ACCW;
            end
`ifdef DECONV_TAIL_CHECK_EN
            for (int jj = 1; jj < LEN1; jj++) begin
                s = 0;
                for (int kk = jj; kk < LEN1; kk++)
                    if (LEN2-1+jj-kk >= 0) s += hm[kk] * xe[LEN2-1+jj-kk];
                if (s != ym[LEN2-1+jj]) e_te = 1;
                e_lat += LEN1 - jj + 1;
            end
`endif
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < LEN1; i++) signal1[i*N +: N] = hm[i][N-1:0];
        for (int i = 0; i < LY; i++)   conv_in[i*2*N +: 2*N] = ym[i][2*N-1:0];
    endtask

    task automatic run(input string tag, input bit poke);
        int cyc, extra;
        bit got_done;
        logic signed [N-1:0] xs;
        model();
        @(negedge clk);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        signal1 = $urandom;
        conv_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        chk({tag, ".busy"}, busy, 1);
        cyc = 0; got_done = 0;
        while (cyc < 2000 && !got_done) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got_done = 1;
            else begin
                start = (poke && cyc == 10);
                if (cyc == 5) begin
                    xs = signal2_out[0 +: N];
                    chk({tag, ".hold_x0"}, xs, xprev[0]);
                    chk({tag, ".hold_flags"}, {div_zero, inexact, overflow, tail_err},
                        {p_dz, p_inx, p_ovf, p_te});
                end
            end
        end
        start = 1'b0;
        chk({tag, ".latency"}, got_done ? cyc : -1, e_lat);
        if (got_done) begin
            for (int i = 0; i < LEN2; i++) begin
                xs = signal2_out[i*N +: N];
                chk($sformatf("%s.x%0d", tag, i), xs, xe[i]);
            end
            chk({tag, ".div_zero"}, div_zero, e_dz);
            chk({tag, ".inexact"}, inexact, e_inx);
            chk({tag, ".overflow"}, overflow, e_ovf);
            chk({tag, ".tail_err"}, tail_err, e_te);
            chk({tag, ".busy_end"}, busy, 0);
        end
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 0);
        if (poke) begin
            extra = 0;
            repeat (200) begin
                @(posedge clk); #1;
                if (done || busy) extra++;
            end
            chk({tag, ".extra_done"}, extra, 0);
        end
        for (int i = 0; i < LEN2; i++) xprev[i] = xe[i];
        p_dz = e_dz; p_inx = e_inx; p_ovf = e_ovf; p_te = e_te;
    endtask

    task automatic set_test1();
        hm = '{1, 2, 1};
        ym = '{1, 1, 2, 5, 3, 0};
    endtask

    task automatic rand_case(input int mode);
        logic signed [N-1:0]   t16;
        logic signed [2*N-1:0] t32;
        longint xr[LEN2];
        for (int i = 0; i < LEN1; i++) hm[i] = longint'($urandom_range(0, 20)) - 10;
        hm[0] = longint'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) hm[0] = -hm[0];
        if (mode == 0) begin
            for (int i = 0; i < LEN2; i++) begin t16 = N'($urandom); xr[i] = t16; end
            for (int i = 0; i < LY; i++) begin
                ym[i] = 0;
                for (int kk = 0; kk < LEN1; kk++)
                    if (i-kk >= 0 && i-kk < LEN2) ym[i] += hm[kk] * xr[i-kk];
            end
        end else begin
            if (mode == 1) begin
                for (int i = 0; i < LEN1; i++) begin t16 = N'($urandom); hm[i] = t16; end
                if (hm[0] == 0) hm[0] = 3;
            end
            if (mode == 3) hm[0] = 0;
            for (int i = 0; i < LY; i++) begin t32 = $urandom; ym[i] = t32; end
        end
    endtask

    initial begin
        for (int i = 0; i < LEN2; i++) xprev[i] = 0;
        p_dz = 0; p_inx = 0; p_ovf = 0; p_te = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.sig2", longint'(signal2_out), 0);
        chk("reset.flags", {div_zero, inexact, overflow, tail_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_test1();
        run("t1", 0);
        hm = '{2, 0, 0}; ym = '{3, -3, 4, 0, 0, 0};
        run("t2", 0);
        hm = '{0, 5, 5}; ym = '{7, 8, 9, 10, 11, 12};
        run("t3", 0);
        hm = '{1, 0, 0}; ym = '{40000, -40000, 0, 0, 0, 0};
        run("t4", 0);
        set_test1(); ym[5] = 7;
        run("t5", 0);
        set_test1();
        run("t6_poke", 1);

        // reset in the middle of a run
        set_test1(); ym[2] = 9;
        @(negedge clk);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.sig2", longint'(signal2_out), 0);
        chk("midrst.flags", {div_zero, inexact, overflow, tail_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LEN2; i++) xprev[i] = 0;
        p_dz = 0; p_inx = 0; p_ovf = 0; p_te = 0;
        set_test1();
        run("after_rst", 0);

        for (int r = 0; r < 14; r++) begin
            rand_case(r % 4);
            run($sformatf("rnd%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
